// File: rtl/cdc_cmd_responder.sv
// cdc_cmd_responder
// Device-side command responder for the usb_cdc byte stream. Host bytes arrive
// on the out_* stream and are decoded as:
//   'W' addr data : single-byte register write, response 'K' (8'h4B)
//   'R' addr      : single-byte register read, response = read data
//   'I'           : ID query, response = ID_BYTE
//   anything else : response '?' (8'h3F)
// Exactly one response byte is returned per command on the in_* stream.
//
// Ports:
//   clk_i, rstn_i            clock, asynchronous active-low reset
//   configured_i             usb_cdc link configured; low aborts everything
//   out_data_i/valid/ready_o host-to-device byte stream
//   in_data_o/valid_o/ready  device-to-host response stream
//   bus_addr_o, bus_wdata_o  register bus address / write data (held)
//   bus_we_o, bus_re_o       one-cycle write / read strobes
//   bus_rdata_i              read data, valid the cycle after bus_re_o
//
// Handshake: a transfer occurs on a rising clk_i edge where valid and ready
// are both high; a valid source holds data stable until that edge.
//
// Optional feature: define CMD_TIMEOUT_EN to abandon a partial command after
// TIMEOUT_CYCLES idle cycles between bytes. Without it a partial command
// waits indefinitely.
module cdc_cmd_responder #(
  parameter int unsigned  ADDR_W         = 8,
  parameter logic [7:0]   ID_BYTE        = 8'hA5,
  parameter logic [23:0]  TIMEOUT_CYCLES = 24'd1000000
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              configured_i,
  input  logic [7:0]        out_data_i,
  input  logic              out_valid_i,
  output logic              out_ready_o,
  output logic [7:0]        in_data_o,
  output logic              in_valid_o,
  input  logic              in_ready_i,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [7:0]        bus_wdata_o,
  output logic              bus_we_o,
  output logic              bus_re_o,
  input  logic [7:0]        bus_rdata_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_W_ADDR, S_W_DATA, S_WRITE, S_R_ADDR, S_READ, S_R_WAIT, S_RESP
  } state_t;

  state_t              state_q;
  logic [7:0]          resp_q;
  logic                in_valid_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          wdata_q;
  logic                we_q;
  logic                re_q;
  logic                byte_states;
  logic                accept;
  logic                tmo_hit;

  // States that are waiting for a host byte.
  assign byte_states = (state_q == S_IDLE)   || (state_q == S_W_ADDR) ||
                       (state_q == S_W_DATA) || (state_q == S_R_ADDR);

  // With the link down every byte is swallowed so the host stream drains.
  assign out_ready_o = byte_states || !configured_i;
  assign accept      = out_valid_i && out_ready_o;

`ifdef CMD_TIMEOUT_EN
  logic [23:0] tmo_q;
  logic        tmo_states;

  assign tmo_states = (state_q == S_W_ADDR) || (state_q == S_W_DATA) ||
                      (state_q == S_R_ADDR);
  assign tmo_hit    = configured_i && tmo_states && !accept &&
                      (tmo_q == TIMEOUT_CYCLES - 24'd1);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tmo_q <= 24'd0;
    end else if (!configured_i || !tmo_states || accept || tmo_hit) begin
      tmo_q <= 24'd0;
    end else begin
      tmo_q <= tmo_q + 24'd1;
    end
  end
`else
  logic unused_tmo;
  assign tmo_hit    = 1'b0;
  assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= S_IDLE;
      resp_q     <= 8'h00;
      in_valid_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 8'h00;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
    end else begin
      we_q <= 1'b0;
      re_q <= 1'b0;
      if (!configured_i) begin
        state_q    <= S_IDLE;
        in_valid_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (accept) begin
              case (out_data_i)
                8'h57:   state_q <= S_W_ADDR;
                8'h52:   state_q <= S_R_ADDR;
                8'h49: begin
                  resp_q     <= ID_BYTE;
                  in_valid_q <= 1'b1;
                  state_q    <= S_RESP;
                end
                default: begin
                  resp_q     <= 8'h3F;
                  in_valid_q <= 1'b1;
                  state_q    <= S_RESP;
                end
              endcase
            end
          end
          S_W_ADDR: begin
            if (accept) begin
              addr_q  <= out_data_i[ADDR_W-1:0];
              state_q <= S_W_DATA;
            end else if (tmo_hit) begin
              state_q <= S_IDLE;
            end
          end
          S_W_DATA: begin
            if (accept) begin
              wdata_q <= out_data_i;
              we_q    <= 1'b1;
              state_q <= S_WRITE;
            end else if (tmo_hit) begin
              state_q <= S_IDLE;
            end
          end
          S_WRITE: begin
            resp_q     <= 8'h4B;
            in_valid_q <= 1'b1;
            state_q    <= S_RESP;
          end
          S_R_ADDR: begin
            if (accept) begin
              addr_q  <= out_data_i[ADDR_W-1:0];
              re_q    <= 1'b1;
              state_q <= S_READ;
            end else if (tmo_hit) begin
              state_q <= S_IDLE;
            end
          end
          S_READ:   state_q <= S_R_WAIT;
          S_R_WAIT: begin
            resp_q     <= bus_rdata_i;
            in_valid_q <= 1'b1;
            state_q    <= S_RESP;
          end
          S_RESP: begin
            if (in_ready_i) begin
              in_valid_q <= 1'b0;
              state_q    <= S_IDLE;
            end
          end
          default:  state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign in_data_o   = resp_q;
  assign in_valid_o  = in_valid_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;
  // A link drop during the strobe cycle itself must still suppress the access.
  assign bus_we_o    = we_q && configured_i;
  assign bus_re_o    = re_q && configured_i;

endmodule

// File: tb/tb_cdc_cmd_responder.sv
module tb_cdc_cmd_responder;

  localparam int AW = 6;
  localparam int MEMN = 1 << AW;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          configured = 1'b1;
  logic [7:0]    out_data = 8'h00;
  logic          out_valid = 1'b0;
  logic          out_ready_o;
  logic [7:0]    in_data_o;
  logic          in_valid_o;
  logic          in_ready = 1'b1;
  logic [AW-1:0] bus_addr_o;
  logic [7:0]    bus_wdata_o;
  logic          bus_we_o;
  logic          bus_re_o;
  logic [7:0]    bus_rdata = 8'h00;

  int checks = 0;
  int errors = 0;

  // reference register file (bench model) and the memory behind the DUT bus
  logic [7:0]  ref_mem   [MEMN];
  logic [7:0]  slave_mem [MEMN];
  logic        rd_pend = 1'b0;
  logic [AW-1:0] rd_addr = '0;

  // observed bus/response events
  logic [15:0] we_evt[$];
  logic [7:0]  re_evt[$];
  logic [7:0]  resp_evt[$];

  // expected events
  logic [7:0]  exp_q[$];
  logic [15:0] exp_we[$];
  logic [7:0]  exp_re[$];

  cdc_cmd_responder #(
    .ADDR_W(AW),
    .ID_BYTE(8'hA5),
    .TIMEOUT_CYCLES(24'd16)
  ) dut (
    .clk_i(clk),
    .rstn_i(rstn),
    .configured_i(configured),
    .out_data_i(out_data),
    .out_valid_i(out_valid),
    .out_ready_o(out_ready_o),
    .in_data_o(in_data_o),
    .in_valid_o(in_valid_o),
    .in_ready_i(in_ready),
    .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o),
    .bus_we_o(bus_we_o),
    .bus_re_o(bus_re_o),
    .bus_rdata_i(bus_rdata)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog sim time exceeded");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Bus slave and event monitor, sampled mid-cycle. Read data is only
  // meaningful in the cycle after bus_re_o; at other times it is noise.
  always @(negedge clk) begin
    if (rd_pend) bus_rdata = slave_mem[rd_addr];
    else         bus_rdata = 8'($urandom);
    rd_pend = bus_re_o;
    rd_addr = bus_addr_o;
    if (bus_re_o) re_evt.push_back(8'(bus_addr_o));
    if (bus_we_o) begin
      we_evt.push_back({8'(bus_addr_o), bus_wdata_o});
      slave_mem[bus_addr_o] = bus_wdata_o;
    end
    if (in_valid_o && in_ready) resp_evt.push_back(in_data_o);
  end

  // ---------------- driver tasks ----------------
  task automatic clear_logs();
    we_evt.delete(); re_evt.delete(); resp_evt.delete();
    exp_q.delete(); exp_we.delete(); exp_re.delete();
  endtask

  // called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send_byte(input logic [7:0] b);
    bit done = 1'b0;
    out_data  = b;
    out_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (out_ready_o) done = 1'b1;
      @(posedge clk); #1;
    end
    out_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_byte_timeout byte=%h accepted=0 required=1", b);
    end
  endtask

  task automatic wait_resp(input int start, input bit rnd);
    bit got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      in_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      if (resp_evt.size() > start) got = 1'b1;
    end
    in_ready = 1'b1;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL resp_timeout responses=%0d required=%0d", resp_evt.size(), start + 1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn = 1'b0;
    #3;
    checks++; if (in_valid_o !== 1'b0) begin errors++; $display("FAIL rst_in_valid got=%b exp=0", in_valid_o); end
    checks++; if (in_data_o !== 8'h00) begin errors++; $display("FAIL rst_in_data got=%h exp=00", in_data_o); end
    checks++; if (bus_we_o !== 1'b0 || bus_re_o !== 1'b0) begin errors++; $display("FAIL rst_strobes got we=%b re=%b exp 0 0", bus_we_o, bus_re_o); end
    checks++; if (bus_addr_o !== '0 || bus_wdata_o !== 8'h00) begin errors++; $display("FAIL rst_bus got addr=%h wdata=%h exp 0 0", bus_addr_o, bus_wdata_o); end
    checks++; if (out_ready_o !== 1'b1) begin errors++; $display("FAIL rst_out_ready got=%b exp=1", out_ready_o); end
    @(posedge clk); #1;
    rstn = 1'b1;
    idle(2);
  endtask

  task automatic test_write();
    clear_logs();
    send_byte(8'h57); send_byte(8'h12); send_byte(8'h3C);
    ref_mem[6'h12] = 8'h3C;
    @(negedge clk); // WRITE cycle
    checks++; if (bus_we_o !== 1'b1) begin errors++; $display("FAIL wr_we got=%b exp=1", bus_we_o); end
    checks++; if (bus_addr_o !== 6'h12 || bus_wdata_o !== 8'h3C) begin errors++; $display("FAIL wr_bus got addr=%h data=%h exp 12 3c", bus_addr_o, bus_wdata_o); end
    checks++; if (out_ready_o !== 1'b0 || in_valid_o !== 1'b0) begin errors++; $display("FAIL wr_cycle1 got ready=%b valid=%b exp 0 0", out_ready_o, in_valid_o); end
    @(negedge clk); // response cycle
    checks++; if (in_valid_o !== 1'b1 || in_data_o !== 8'h4B) begin errors++; $display("FAIL wr_resp got valid=%b data=%h exp 1 4b", in_valid_o, in_data_o); end
    checks++; if (out_ready_o !== 1'b0 || bus_we_o !== 1'b0) begin errors++; $display("FAIL wr_cycle2 got ready=%b we=%b exp 0 0", out_ready_o, bus_we_o); end
    @(negedge clk);
    checks++; if (in_valid_o !== 1'b0 || out_ready_o !== 1'b1) begin errors++; $display("FAIL wr_done got valid=%b ready=%b exp 0 1", in_valid_o, out_ready_o); end
    @(posedge clk); #1;
    checks++; if (we_evt.size() != 1 || resp_evt.size() != 1 || re_evt.size() != 0) begin errors++; $display("FAIL wr_counts got we=%0d resp=%0d re=%0d exp 1 1 0", we_evt.size(), resp_evt.size(), re_evt.size()); end
  endtask

  task automatic test_read();
    clear_logs();
    send_byte(8'h52); send_byte(8'h12);
    @(negedge clk); // READ cycle
    checks++; if (bus_re_o !== 1'b1 || bus_addr_o !== 6'h12) begin errors++; $display("FAIL rd_re got re=%b addr=%h exp 1 12", bus_re_o, bus_addr_o); end
    @(negedge clk); // R_WAIT
    checks++; if (bus_re_o !== 1'b0 || in_valid_o !== 1'b0) begin errors++; $display("FAIL rd_wait got re=%b valid=%b exp 0 0", bus_re_o, in_valid_o); end
    @(negedge clk);
    checks++; if (in_valid_o !== 1'b1 || in_data_o !== ref_mem[6'h12]) begin errors++; $display("FAIL rd_resp got valid=%b data=%h exp 1 %h", in_valid_o, in_data_o, ref_mem[6'h12]); end
    idle(2);
    checks++; if (re_evt.size() != 1 || we_evt.size() != 0 || resp_evt.size() != 1) begin errors++; $display("FAIL rd_counts got re=%0d we=%0d resp=%0d exp 1 0 1", re_evt.size(), we_evt.size(), resp_evt.size()); end
  endtask

  task automatic test_id_unknown();
    bit stable = 1'b1;
    clear_logs();
    in_ready = 1'b0;
    send_byte(8'h49);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (in_valid_o !== 1'b1 || in_data_o !== 8'hA5 || out_ready_o !== 1'b0) stable = 1'b0;
    end
    checks++; if (!stable) begin errors++; $display("FAIL id_stall_stable got valid=%b data=%h exp 1 a5", in_valid_o, in_data_o); end
    @(posedge clk); #1;
    wait_resp(0, 1'b0);
    checks++; if (resp_evt.size() != 1 || resp_evt[0] !== 8'hA5) begin errors++; $display("FAIL id_resp got n=%0d exp n=1 data a5", resp_evt.size()); end
    send_byte(8'h00);
    wait_resp(1, 1'b0);
    checks++; if (resp_evt.size() != 2 || resp_evt[1] !== 8'h3F) begin errors++; $display("FAIL unk_resp got n=%0d exp n=2 data 3f", resp_evt.size()); end
    checks++; if (we_evt.size() != 0 || re_evt.size() != 0) begin errors++; $display("FAIL id_strobes got we=%0d re=%0d exp 0 0", we_evt.size(), re_evt.size()); end
  endtask

  task automatic test_link_drop();
    clear_logs();
    send_byte(8'h57); send_byte(8'h12);
    configured = 1'b0;
    @(negedge clk);
    checks++; if (out_ready_o !== 1'b1) begin errors++; $display("FAIL drop_ready got=%b exp=1", out_ready_o); end
    @(posedge clk); #1;
    configured = 1'b1;
    send_byte(8'h52); send_byte(8'h34);
    wait_resp(0, 1'b0);
    idle(2);
    checks++; if (we_evt.size() != 0) begin errors++; $display("FAIL drop_no_write got=%0d exp=0", we_evt.size()); end
    checks++; if (re_evt.size() != 1 || re_evt[0] !== 8'h34) begin errors++; $display("FAIL drop_read got n=%0d exp n=1 addr 34", re_evt.size()); end
    checks++; if (resp_evt.size() != 1 || resp_evt[0] !== ref_mem[6'h34]) begin errors++; $display("FAIL drop_resp got n=%0d exp n=1 data %h", resp_evt.size(), ref_mem[6'h34]); end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    send_byte(8'h52); send_byte(8'h12);
    @(posedge clk); #2; // now in R_WAIT
    rstn = 1'b0;
    #1;
    checks++; if (in_valid_o !== 1'b0 || bus_re_o !== 1'b0 || bus_we_o !== 1'b0) begin errors++; $display("FAIL midrst_ctrl got valid=%b re=%b we=%b exp 0 0 0", in_valid_o, bus_re_o, bus_we_o); end
    checks++; if (bus_addr_o !== '0 || in_data_o !== 8'h00 || bus_wdata_o !== 8'h00) begin errors++; $display("FAIL midrst_data got addr=%h data=%h wdata=%h exp 0 0 0", bus_addr_o, in_data_o, bus_wdata_o); end
    checks++; if (out_ready_o !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b exp=1", out_ready_o); end
    @(posedge clk); #1;
    rstn = 1'b1;
    idle(6);
    checks++; if (resp_evt.size() != 0) begin errors++; $display("FAIL midrst_no_resp got=%0d exp=0", resp_evt.size()); end
  endtask

`ifdef CMD_TIMEOUT_EN
  task automatic test_timeout();
    clear_logs();
    send_byte(8'h57); send_byte(8'h12);
    idle(16);
    send_byte(8'h49);
    wait_resp(0, 1'b0);
    idle(2);
    checks++; if (we_evt.size() != 0) begin errors++; $display("FAIL tmo_no_write got=%0d exp=0", we_evt.size()); end
    checks++; if (resp_evt.size() != 1 || resp_evt[0] !== 8'hA5) begin errors++; $display("FAIL tmo_resp got n=%0d exp n=1 data a5", resp_evt.size()); end
  endtask
`endif

  task automatic test_random();
    logic [7:0] a, d, b;
    int k;
    clear_logs();
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 3);
      a = 8'($urandom);
      d = 8'($urandom);
      case (k)
        0: begin
          send_byte(8'h57); send_byte(a); send_byte(d);
          ref_mem[a % MEMN] = d;
          exp_we.push_back({8'(a % MEMN), d});
          exp_q.push_back(8'h4B);
        end
        1: begin
          send_byte(8'h52); send_byte(a);
          exp_re.push_back(8'(a % MEMN));
          exp_q.push_back(ref_mem[a % MEMN]);
        end
        2: begin
          send_byte(8'h49);
          exp_q.push_back(8'hA5);
        end
        default: begin
          b = 8'($urandom);
          while (b == 8'h57 || b == 8'h52 || b == 8'h49) b = 8'($urandom);
          send_byte(b);
          exp_q.push_back(8'h3F);
        end
      endcase
      wait_resp(exp_q.size() - 1, 1'b1);
    end
    idle(3);
    checks++; if (resp_evt.size() != exp_q.size()) begin errors++; $display("FAIL rnd_resp_count got=%0d exp=%0d", resp_evt.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < resp_evt.size(); i++) begin
      checks++; if (resp_evt[i] !== exp_q[i]) begin errors++; $display("FAIL rnd_resp[%0d] got=%h exp=%h", i, resp_evt[i], exp_q[i]); end
    end
    checks++; if (we_evt.size() != exp_we.size() || re_evt.size() != exp_re.size()) begin errors++; $display("FAIL rnd_bus_count got we=%0d re=%0d exp %0d %0d", we_evt.size(), re_evt.size(), exp_we.size(), exp_re.size()); end
    for (int i = 0; i < exp_we.size() && i < we_evt.size(); i++) begin
      checks++; if (we_evt[i] !== exp_we[i]) begin errors++; $display("FAIL rnd_we[%0d] got=%h exp=%h", i, we_evt[i], exp_we[i]); end
    end
    for (int i = 0; i < exp_re.size() && i < re_evt.size(); i++) begin
      checks++; if (re_evt[i] !== exp_re[i]) begin errors++; $display("FAIL rnd_re[%0d] got=%h exp=%h", i, re_evt[i], exp_re[i]); end
    end
  endtask

  initial begin
    for (int i = 0; i < MEMN; i++) begin
      ref_mem[i]   = 8'($urandom);
      slave_mem[i] = ref_mem[i];
    end
    ref_mem[6'h34]   = 8'h5A;
    slave_mem[6'h34] = 8'h5A;
    test_reset();
    test_write();
    test_read();
    test_id_unknown();
    test_link_drop();
    test_reset_mid();
`ifdef CMD_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdc_cmd_responder.md
Name: cdc_cmd_responder

Overview:
- Byte-stream command responder on the device side of usb_cdc.
- Consumes host bytes from the usb_cdc out_* stream and decodes read, write and ID commands.
- Performs single-byte accesses on a simple register bus.
- Returns one response byte per command on the usb_cdc in_* stream.

Parameters:
- ADDR_W, 8, register bus address width (1..8); address = low ADDR_W bits of the address byte.
- ID_BYTE, 8'hA5, value returned by the ID command.
- TIMEOUT_CYCLES, 24'd1000000, inter-byte timeout in clk_i cycles (used only with CMD_TIMEOUT_EN).

Ports:
- clk_i  in  1  system clock, same clock as usb_cdc app_clk_i.
- rstn_i  in  1  asynchronous active-low reset.
- configured_i  in  1  usb_cdc configured_o; low = link down.
- out_data_i  in  8  host-to-device byte.
- out_valid_i  in  1  out_data_i valid.
- out_ready_o  out  1  responder accepts byte.
- in_data_o  out  8  response byte.
- in_valid_o  out  1  response valid.
- in_ready_i  in  1  usb_cdc accepts response.
- bus_addr_o  out  ADDR_W  register address.
- bus_wdata_o  out  8  write data.
- bus_we_o  out  1  write strobe, one cycle.
- bus_re_o  out  1  read strobe, one cycle.
- bus_rdata_i  in  8  read data, valid the cycle after bus_re_o.

Behaviour:
- Reset (rstn_i low, asynchronous):
  - state = IDLE.
  - in_valid_o, bus_we_o, bus_re_o = 0; in_data_o, bus_addr_o, bus_wdata_o = 0.
  - out_ready_o = 1 (decoded from state).
- A byte is accepted when out_valid_i && out_ready_o on a rising clk_i.
- out_ready_o = 1 only in IDLE, W_ADDR, W_DATA and R_ADDR.
- States and transitions:
  - IDLE:
    - 8'h57 ('W') -> W_ADDR.
    - 8'h52 ('R') -> R_ADDR.
    - 8'h49 ('I'): resp = ID_BYTE -> RESP.
    - Any other byte: resp = 8'h3F ('?') -> RESP.
  - W_ADDR: byte -> bus_addr_o latched -> W_DATA.
  - W_DATA: byte -> bus_wdata_o latched -> WRITE.
  - WRITE: bus_we_o = 1 for exactly this cycle; resp = 8'h4B ('K') -> RESP.
  - R_ADDR: byte -> bus_addr_o latched -> READ.
  - READ: bus_re_o = 1 for exactly this cycle -> R_WAIT.
  - R_WAIT: resp = bus_rdata_i captured -> RESP.
  - RESP:
    - in_valid_o = 1 and in_data_o = resp, both held stable until in_ready_i.
    - Handshake cycle (in_valid_o && in_ready_i) -> IDLE; in_valid_o = 0 next cycle.
- Latency:
  - Last write byte accepted -> bus_we_o next cycle -> in_valid_o the cycle after.
  - Read address accepted -> bus_re_o +1 -> capture +2 -> in_valid_o +3.
- bus_addr_o and bus_wdata_o hold their last value outside strobes.
- Back-to-back commands: a new command byte is accepted only in IDLE. There is no pipelining; the host must wait for the response.
- configured_i low:
  - Synchronous return to IDLE on the next edge.
  - Pending response dropped; in_valid_o = 0.
  - No bus strobe issued, including from WRITE/READ states.
  - out_ready_o = 1, so stray bytes are discarded without decoding.
- An address byte is truncated to ADDR_W bits; upper bits are ignored silently.

Optional Feature:
- Macro: CMD_TIMEOUT_EN.
- Defined:
  - A 24-bit counter clears on every accepted byte and counts in W_ADDR, W_DATA and R_ADDR.
  - When it reaches TIMEOUT_CYCLES-1, the parser returns to IDLE, emits no response and issues no bus strobe.
  - The counter is held at 0 in all other states.
- Not defined:
  - No counter logic is present.
  - A partial command waits indefinitely for its remaining bytes.

Test Plan:
- Write: send 57 12 3C with in_ready_i=1 -> one cycle bus_we_o=1 with bus_addr_o=12, bus_wdata_o=3C; then in_data_o=4B for one valid cycle; out_ready_o=0 from WRITE until the handshake.
- Read: send 52 12, bench returns bus_rdata_i=3C the cycle after bus_re_o -> single bus_re_o pulse at addr 12; response byte 3C.
- ID and unknown: send 49 then 00 -> responses A5 then 3F; with in_ready_i held low 10 cycles, in_valid_o and in_data_o stay stable; no bus strobes.
- Link drop: send 57 12, deassert configured_i for 1 cycle, then send 52 34 -> no write strobe; only a read of addr 34 occurs.
- Reset mid-command: assert rstn_i low asynchronously in R_WAIT -> outputs zero immediately and out_ready_o=1; no response emitted after release.
- Timeout (CMD_TIMEOUT_EN, TIMEOUT_CYCLES=16): send 57 12, idle 16 cycles, send 49 -> no write; response A5.
